// File: rtl/puf_cmd_parser.sv
// Byte-stream command parser for the PUF controller.
// Frames bytes from uart_rx as SYNC, CMD, N_BYTES payload (MSB first), XOR checksum.
// A validated {cmd, challenge} is held behind a valid/ready handshake.
// Checksum, inter-byte timeout and overrun are reported as one-cycle err pulses.
module puf_cmd_parser #(
  parameter int unsigned N_BYTES        = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_cmd,
  output logic [8*N_BYTES-1:0]   out_challenge,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   busy
);

  localparam int unsigned ChW  = 8 * N_BYTES;
  localparam int unsigned CntW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(N_BYTES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ErrCsum    = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrOverrun = 2'b11;

  typedef enum logic [1:0] {
    StHunt,
    StCmd,
    StPayload,
    StCheck
  } state_e;

  // rx_done comes from the divided-clock domain
  logic sync1_q, sync2_q, sync3_q;
  logic byte_stb;

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [ChW-1:0]  shreg_q, shreg_d;
  logic [7:0]      csum_q, csum_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ToW-1:0]  tmo_q, tmo_d;

  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_cmd_q, out_cmd_d;
  logic [ChW-1:0]  out_chal_q, out_chal_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            accept;
  logic            timeout_hit;

  // Two-flop synchronizer plus an edge-detect flop on rx_done
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= rx_done;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign byte_stb = sync2_q & ~sync3_q;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHunt;
      cmd_q       <= '0;
      shreg_q     <= '0;
      csum_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_chal_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      shreg_q     <= shreg_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      out_chal_q  <= out_chal_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign accept = out_valid_q & out_ready;

  // A strobe in the same cycle always beats the timeout
  assign timeout_hit = (state_q != StHunt) && !byte_stb && (tmo_q == ToLast);

  // Framing FSM, checksum/overrun decision and timeout
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    shreg_d     = shreg_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_cmd_d   = out_cmd_q;
    out_chal_d  = out_chal_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    if (state_q == StHunt || byte_stb) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + ToW'(1);
    end

    case (state_q)
      StHunt: begin
        if (byte_stb && rx_data == SYNC_BYTE) begin
          state_d = StCmd;
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      StCmd: begin
        if (byte_stb) begin
          cmd_d   = rx_data;
          csum_d  = rx_data;
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (byte_stb) begin
          shreg_d = (shreg_q << 8) | ChW'(rx_data);
          csum_d  = csum_q ^ rx_data;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (byte_stb) begin
          state_d = StHunt;
          if (rx_data == csum_q) begin
            // The held frame may be retired in the same cycle a new one lands
            if (!out_valid_q || accept) begin
              out_valid_d = 1'b1;
              out_cmd_d   = cmd_q;
              out_chal_d  = shreg_q;
            end else begin
              err_d      = 1'b1;
              err_code_d = ErrOverrun;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrCsum;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (timeout_hit) begin
      state_d    = StHunt;
      tmo_d      = '0;
      err_d      = 1'b1;
      err_code_d = ErrTimeout;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_cmd       = out_cmd_q;
  assign out_challenge = out_chal_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign busy          = (state_q != StHunt);

endmodule
